// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_sequencer : hardwired Moore control unit for the datapath bus.     |
// | Optional CU_ILLEGAL_TRAP_EN sends unlisted opcodes to an absorbing TRAP.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module control_sequencer #(
   parameter int unsigned MEM_WAIT = 0,
   parameter logic [4:0]  ADD_OP   = 5'b00011,
   parameter logic [4:0]  BR_OP    = 5'b10011
) (
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON,
   input  logic        stop,
   output logic [4:0]  opcode,
   output logic        Read,
   output logic        Write,
   output logic        IncPC,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Yin,
   output logic        Zin,
   output logic        PCin,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        CONin,
   output logic        PCout,
   output logic        MDRout,
   output logic        Zlowout,
   output logic        Cout,
   output logic        HIin,
   output logic        LOin,
   output logic        HIout,
   output logic        LOout,
   output logic        Yout,
   output logic        Zhighout,
   output logic        MARout,
   output logic        Inportin,
   output logic        Inportout,
   output logic        Outportin,
   output logic        Outportout,
   output logic        run,
   output logic [3:0]  t_state
);

   typedef enum logic [3:0] {
      ST_RST   = 4'd0,
      ST_T0    = 4'd1,
      ST_T1    = 4'd2,
      ST_T2    = 4'd3,
      ST_T3    = 4'd4,
      ST_T4    = 4'd5,
      ST_T5    = 4'd6,
      ST_T6    = 4'd7,
      ST_T7    = 4'd8,
      ST_PAUSE = 4'd9,
      ST_HALT  = 4'd10,
      ST_TRAP  = 4'd11
   } state_t;

   localparam logic [4:0] c_op_ld   = 5'b00000;
   localparam logic [4:0] c_op_add  = 5'b00011;
   localparam logic [4:0] c_op_sub  = 5'b00100;
   localparam logic [4:0] c_op_and  = 5'b00101;
   localparam logic [4:0] c_op_or   = 5'b00110;
   localparam logic [4:0] c_op_addi = 5'b01100;
   localparam logic [4:0] c_op_br   = 5'b10010;
   localparam logic [4:0] c_op_nop  = 5'b11010;
   localparam logic [4:0] c_op_halt = 5'b11011;

   localparam logic [2:0] c_mem_wait = 3'(MEM_WAIT);

`ifdef CU_ILLEGAL_TRAP_EN
   localparam logic c_trap_en = 1'b1;
`else
   localparam logic c_trap_en = 1'b0;
`endif

   state_t     state_q, state_d;
   logic [2:0] wait_q, wait_d;

   logic [4:0] w_op;
   logic       w_is_ld, w_is_alu, w_is_addi, w_is_br, w_is_nop, w_is_halt;
   logic       w_is_legal, w_wait_done;
   state_t     w_t0_next;
   logic       w_ir_unused;

   assign w_op        = IR[31:27];
   assign w_ir_unused = ^IR[26:0];

   assign w_is_ld    = (w_op == c_op_ld);
   assign w_is_alu   = (w_op == c_op_add) || (w_op == c_op_sub) ||
                       (w_op == c_op_and) || (w_op == c_op_or);
   assign w_is_addi  = (w_op == c_op_addi);
   assign w_is_br    = (w_op == c_op_br);
   assign w_is_nop   = (w_op == c_op_nop);
   assign w_is_halt  = (w_op == c_op_halt);
   assign w_is_legal = w_is_ld | w_is_alu | w_is_addi | w_is_br | w_is_nop | w_is_halt;

   assign w_wait_done = (wait_q == c_mem_wait);

   // Every completed instruction funnels through here so stop is honoured uniformly.
   assign w_t0_next = stop ? ST_PAUSE : ST_T0;

   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         state_q <= ST_RST;
         wait_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = 3'd0;
      case (state_q)
         ST_RST: state_d = w_t0_next;
         ST_T0:  state_d = ST_T1;
         ST_T1: begin
            if (w_wait_done) state_d = ST_T2;
            else             wait_d  = wait_q + 3'd1;
         end
         ST_T2: begin
            if (w_is_nop || (!w_is_legal && !c_trap_en)) state_d = w_t0_next;
            else                                         state_d = ST_T3;
         end
         ST_T3: begin
            if (w_is_halt)       state_d = ST_HALT;
            else if (!w_is_legal) state_d = c_trap_en ? ST_TRAP : w_t0_next;
            else if (w_is_nop)   state_d = w_t0_next;
            else                 state_d = ST_T4;
         end
         ST_T4: begin
            if (w_is_alu || w_is_addi || w_is_ld || w_is_br) state_d = ST_T5;
            else                                             state_d = w_t0_next;
         end
         ST_T5: begin
            if (w_is_ld || w_is_br) state_d = ST_T6;
            else                    state_d = w_t0_next;
         end
         ST_T6: begin
            if (w_is_ld) begin
               if (w_wait_done) state_d = ST_T7;
               else             wait_d  = wait_q + 3'd1;
            end else begin
               state_d = w_t0_next;
            end
         end
         ST_T7:    state_d = w_t0_next;
         ST_PAUSE: if (!stop) state_d = ST_T0;
         ST_HALT:  state_d = ST_HALT;
         ST_TRAP:  state_d = ST_TRAP;
         default:  state_d = ST_RST;
      endcase
   end

   always_comb begin
      opcode  = 5'd0;
      Read    = 1'b0;
      Write   = 1'b0;
      IncPC   = 1'b0;
      Gra     = 1'b0;
      Grb     = 1'b0;
      Grc     = 1'b0;
      Rin     = 1'b0;
      Rout    = 1'b0;
      BAout   = 1'b0;
      Yin     = 1'b0;
      Zin     = 1'b0;
      PCin    = 1'b0;
      IRin    = 1'b0;
      MARin   = 1'b0;
      MDRin   = 1'b0;
      CONin   = 1'b0;
      PCout   = 1'b0;
      MDRout  = 1'b0;
      Zlowout = 1'b0;
      Cout    = 1'b0;
      run     = 1'b0;
      case (state_q)
         ST_T0: begin
            run   = 1'b1;
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         ST_T1: begin
            // PC is written once, on the cycle the memory read completes.
            run     = 1'b1;
            Zlowout = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            PCin    = w_wait_done;
         end
         ST_T2: begin
            run    = 1'b1;
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            run = 1'b1;
            if (w_is_alu || w_is_addi) begin
               Grb  = 1'b1;
               Rout = 1'b1;
               Yin  = 1'b1;
            end else if (w_is_ld) begin
               Grb   = 1'b1;
               BAout = 1'b1;
               Yin   = 1'b1;
            end else if (w_is_br) begin
               Gra   = 1'b1;
               Rout  = 1'b1;
               CONin = 1'b1;
            end
         end
         ST_T4: begin
            run = 1'b1;
            if (w_is_alu) begin
               Grc    = 1'b1;
               Rout   = 1'b1;
               Zin    = 1'b1;
               opcode = w_op;
            end else if (w_is_addi || w_is_ld) begin
               Cout   = 1'b1;
               Zin    = 1'b1;
               opcode = ADD_OP;
            end else if (w_is_br) begin
               PCout = 1'b1;
               Yin   = 1'b1;
            end
         end
         ST_T5: begin
            run = 1'b1;
            if (w_is_alu || w_is_addi) begin
               Zlowout = 1'b1;
               Gra     = 1'b1;
               Rin     = 1'b1;
            end else if (w_is_ld) begin
               Zlowout = 1'b1;
               MARin   = 1'b1;
            end else if (w_is_br) begin
               Cout   = 1'b1;
               Zin    = 1'b1;
               opcode = BR_OP;
            end
         end
         ST_T6: begin
            run = 1'b1;
            if (w_is_ld) begin
               Read  = 1'b1;
               MDRin = 1'b1;
            end else if (w_is_br) begin
               Zlowout = CON;
               PCin    = CON;
            end
         end
         ST_T7: begin
            run = 1'b1;
            if (w_is_ld) begin
               MDRout = 1'b1;
               Gra    = 1'b1;
               Rin    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign HIin       = 1'b0;
   assign LOin       = 1'b0;
   assign HIout      = 1'b0;
   assign LOout      = 1'b0;
   assign Yout       = 1'b0;
   assign Zhighout   = 1'b0;
   assign MARout     = 1'b0;
   assign Inportin   = 1'b0;
   assign Inportout  = 1'b0;
   assign Outportin  = 1'b0;
   assign Outportout = 1'b0;

   assign t_state = state_q;

endmodule
`default_nettype wire
